// File: rtl/circ_queue_pkg.sv
// Shared types and helpers for the circular queue pointer controller:
// the flag/value pointer pair, pointer advance and pointer distance.
package circ_queue_pkg;

    localparam int DEF_SIZE  = 32;
    localparam int DEF_VAL_W = 8;
    localparam int DEF_CNT_W = 5;

    typedef struct packed {
        logic                 flag;
        logic [DEF_VAL_W-1:0] value;
    } circ_ptr_t;

    // n never exceeds size for an accepted request, so one subtraction covers the wrap
    function automatic circ_ptr_t circ_ptr_add(circ_ptr_t ptr, logic [DEF_VAL_W:0] n,
                                               logic [DEF_VAL_W:0] size);
        logic [DEF_VAL_W:0] s;
        logic [DEF_VAL_W:0] t;
        circ_ptr_t          r;
        s = {1'b0, ptr.value} + n;
        t = s - size;
        r = ptr;
        if (s >= size) begin
            r.value = t[DEF_VAL_W-1:0];
            r.flag  = ~ptr.flag;
        end else begin
            r.value = s[DEF_VAL_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [DEF_VAL_W:0] circ_ptr_dist(circ_ptr_t enq, circ_ptr_t deq,
                                                         logic [DEF_VAL_W:0] size);
        logic [DEF_VAL_W:0] d;
        if (enq.flag == deq.flag)
            d = {1'b0, enq.value} - {1'b0, deq.value};
        else
            d = size + {1'b0, enq.value} - {1'b0, deq.value};
        return d;
    endfunction

endpackage

// File: rtl/circ_ptr_reg.sv
// One registered flag/value pointer that advances by n entries with wrap
// at SIZE. Used for both the enqueue and the dequeue side.
module circ_ptr_reg
    import circ_queue_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int VAL_W = DEF_VAL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [VAL_W:0]   n,
    output logic             ptr_flag,
    output logic [VAL_W-1:0] ptr_value
);

    localparam logic [VAL_W:0] SIZE_V = SIZE[VAL_W:0];

    circ_ptr_t ptr_q;

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else if (adv)
            ptr_q <= circ_ptr_add(ptr_q, n, SIZE_V);
    end

    assign ptr_flag  = ptr_q.flag;
    assign ptr_value = ptr_q.value;

endmodule

// File: rtl/circ_queue_ptr.sv
// Enqueue/dequeue pointer controller for a SIZE-entry ring buffer.
// Define CIRC_QUEUE_PTR_ERR_EN to latch underflow requests into the sticky err flag.
module circ_queue_ptr
    import circ_queue_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int VAL_W = DEF_VAL_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    input  logic [CNT_W-1:0] enq_cnt0,
    input  logic [CNT_W-1:0] enq_cnt1,
    input  logic [CNT_W-1:0] enq_cnt2,
    output logic             enq_ready,
    input  logic             deq_valid,
    input  logic [CNT_W-1:0] deq_cnt,
    output logic             enq_ptr_flag,
    output logic [VAL_W-1:0] enq_ptr_value,
    output logic             deq_ptr_flag,
    output logic [VAL_W-1:0] deq_ptr_value,
    output logic [VAL_W:0]   used,
    output logic [VAL_W:0]   free,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam logic [VAL_W:0] SIZE_V = SIZE[VAL_W:0];
    localparam int             WIDE_W = VAL_W + CNT_W + 2;

    logic [CNT_W+1:0]  enq_total;
    logic [WIDE_W-1:0] total_w;
    logic [WIDE_W-1:0] free_w;
    logic [WIDE_W-1:0] used_w;
    logic [WIDE_W-1:0] deq_w;
    logic              deq_ok;
    logic              enq_fire;
    logic              deq_fire;
    circ_ptr_t         enq_cur;
    circ_ptr_t         deq_cur;

    // Compare at a common width so neither the lane sum nor the occupancy is truncated
    assign enq_total = {2'b00, enq_cnt0} + {2'b00, enq_cnt1} + {2'b00, enq_cnt2};
    assign total_w   = {{VAL_W{1'b0}}, enq_total};
    assign free_w    = {{(CNT_W+1){1'b0}}, free};
    assign used_w    = {{(CNT_W+1){1'b0}}, used};
    assign deq_w     = {{(VAL_W+2){1'b0}}, deq_cnt};

    assign enq_ready = (total_w <= free_w);
    assign deq_ok    = (deq_w <= used_w);
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ok;

    circ_ptr_reg #(.SIZE(SIZE), .VAL_W(VAL_W)) u_enq_ptr (
        .clk       (clk),
        .rst       (rst),
        .adv       (enq_fire),
        .n         (total_w[VAL_W:0]),
        .ptr_flag  (enq_ptr_flag),
        .ptr_value (enq_ptr_value)
    );

    circ_ptr_reg #(.SIZE(SIZE), .VAL_W(VAL_W)) u_deq_ptr (
        .clk       (clk),
        .rst       (rst),
        .adv       (deq_fire),
        .n         (deq_w[VAL_W:0]),
        .ptr_flag  (deq_ptr_flag),
        .ptr_value (deq_ptr_value)
    );

    assign enq_cur = {enq_ptr_flag, enq_ptr_value};
    assign deq_cur = {deq_ptr_flag, deq_ptr_value};
    assign used    = circ_ptr_dist(enq_cur, deq_cur, SIZE_V);
    assign free    = SIZE_V - used;
    assign full    = (used == SIZE_V);
    assign empty   = (used == '0);

`ifdef CIRC_QUEUE_PTR_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (deq_valid && !deq_ok)
            err_q <= 1'b1;
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(deq_valid && !deq_ok))
                else $error("circ_queue_ptr: dequeue of %0d with only %0d used", deq_cnt, used);
    end
`endif
`else
    assign err = 1'b0;
`endif

endmodule
